// File: rtl/exe_muldiv_seq.sv
// Sequential RISC-V M-extension unit: radix-2 shift-add multiply, restoring divide.
// One iteration per clock on operand magnitudes; sign fix-up applied in DONE.
module exe_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [2:0]         op_q;
  logic               neg_q, neg_r;
  logic [WIDTH-1:0]   divs_q;   // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] prod_q;   // low half: multiplier / dividend, becomes quotient
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   result_q;

  // request decode
  logic             is_div, sgn1, sgn2, neg1, neg2, div_zero, div_ovf, special, accept;
  logic [WIDTH-1:0] mag1, mag2;

  always_comb begin
    is_div   = op_i[2];
    sgn1     = is_div ? ~op_i[0] : (op_i[1:0] == 2'b01 || op_i[1:0] == 2'b10);
    sgn2     = is_div ? ~op_i[0] : (op_i[1:0] == 2'b01);
    neg1     = sgn1 & op1_i[WIDTH-1];
    neg2     = sgn2 & op2_i[WIDTH-1];
    mag1     = neg1 ? -op1_i : op1_i;
    mag2     = neg2 ? -op2_i : op2_i;
    div_zero = is_div && (op2_i == '0);
    div_ovf  = is_div && !op_i[0] && (op1_i == {1'b1, {(WIDTH-1){1'b0}}}) && (op2_i == '1);
    special  = div_zero | div_ovf;
    accept   = (state_q == IDLE) && start_i && !flush_i;
  end

  // iteration step
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   rem_next, quo_next;

  always_comb begin
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, divs_q};
    mul_next  = prod_q[0] ? {mul_sum, prod_q[WIDTH-1:1]} : {1'b0, prod_q[2*WIDTH-1:1]};
    div_shift = {rem_q, prod_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, divs_q};
    // a borrow means the divisor did not fit: keep the shifted remainder
    rem_next  = div_diff[WIDTH+1] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    quo_next  = {prod_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
  end

  // sign correction and result selection
  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0]   quo_raw, quo_c, rem_c, res_calc;

  always_comb begin
    quo_raw = prod_q[WIDTH-1:0];
    prod_c  = neg_q ? -prod_q : prod_q;
    quo_c   = neg_q ? -quo_raw : quo_raw;
    rem_c   = neg_r ? -rem_q : rem_q;
    case (op_q)
      3'b000:                 res_calc = prod_c[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: res_calc = prod_c[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         res_calc = quo_c;
      default:                res_calc = rem_c;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        stall_o = start_i;
        if (start_i) state_d = special ? DONE : CALC;
      end
      CALC: begin
        stall_o = 1'b1;
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      divs_q   <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q   <= op_i;
        divs_q <= mag2;
        if (div_zero) begin
          // preload registers so the normal DONE path yields the fixed results
          cnt_q  <= '0;
          neg_q  <= 1'b0;
          neg_r  <= 1'b0;
          prod_q <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
          rem_q  <= op1_i;
        end else if (div_ovf) begin
          cnt_q  <= '0;
          neg_q  <= 1'b0;
          neg_r  <= 1'b0;
          prod_q <= {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
          rem_q  <= '0;
        end else begin
          cnt_q  <= CW'(WIDTH);
          neg_q  <= neg1 ^ neg2;
          neg_r  <= neg1;
          prod_q <= {{WIDTH{1'b0}}, mag1};
          rem_q  <= '0;
        end
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q - CW'(1);
        if (op_q[2]) begin
          prod_q[WIDTH-1:0] <= quo_next;
          rem_q             <= rem_next;
        end else begin
          prod_q <= mul_next;
        end
      end
      if (state_q == DONE) result_q <= res_calc;
    end
  end

  assign result_o = (state_q == DONE) ? res_calc : result_q;

endmodule

// File: tb/tb_exe_muldiv_seq.sv
// Bench for exe_muldiv_seq: directed vector table, flush/reset/hold sequences,
// and random operations against a plain-arithmetic reference model.
module tb_exe_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        stall_o, valid_o;
  logic [31:0] result_o;

  int n_pass = 0;
  int n_total = 0;

  exe_muldiv_seq #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op), .op1_i(a), .op2_i(b),
    .flush_i(flush), .stall_o(stall_o), .valid_o(valid_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       tag;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * longint'({32'b0, y}); return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        return 32'(int'(x) / int'(y));
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        return 32'(int'(x) % int'(y));
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && y == 0) return 1;
    if (o[2] && !o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Called just after a falling edge with the DUT idle; returns at a falling edge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input string tag);
    int  lat;
    bit  stall_ok;
    start = 1'b1; op = o; a = x; b = y;
    #1 check({tag, " stall_on_accept"}, stall_o, 1);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    stall_ok = 1'b1;
    while (!valid_o && lat < 100) begin
      if (!stall_o) stall_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, exp_latency(o, x, y));
    check({tag, " result"}, result_o, exp);
    check({tag, " stall_busy"}, stall_ok, 1);
    check({tag, " stall_done"}, stall_o, 0);
    @(negedge clk);
    check({tag, " valid_one_cycle"}, valid_o, 0);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    int pulses;
    pulses = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (valid_o) pulses++;
    end
    check(name, pulses, 0);
  endtask

  vec_t vecs[$];

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb, held;
    int          lat;

    vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, "mul"});
    vecs.push_back('{3'd1, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFFF, "mulh"});
    vecs.push_back('{3'd3, 32'd7,          32'hFFFF_FFFA, 32'h0000_0006, "mulhu"});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu"});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div"});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem"});
    vecs.push_back('{3'd5, 32'd100,        32'd7,         32'd14,        "divu"});
    vecs.push_back('{3'd7, 32'd100,        32'd7,         32'd2,         "remu"});
    vecs.push_back('{3'd5, 32'h1234,       32'd0,         32'hFFFF_FFFF, "divu_by0"});
    vecs.push_back('{3'd7, 32'h1234,       32'd0,         32'h0000_1234, "remu_by0"});
    vecs.push_back('{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, "div_by0"});
    vecs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"});
    vecs.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf"});

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("reset valid", valid_o, 0);
    check("reset stall", stall_o, 0);
    check("reset result", result_o, 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].tag);

    // flush in the 10th CALC cycle, then restart straight away
    start = 1'b1; op = 3'd0; a = 32'd7; b = 32'hFFFF_FFFA;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush valid", valid_o, 0);
    check("flush stall", stall_o, 0);
    run_op(3'd5, 32'd1000, 32'd33, 32'd30, "after_flush");

    // flush wins over start in IDLE
    start = 1'b1; flush = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1 check("flush_vs_start stall", stall_o, 0);
    expect_quiet("flush_vs_start no valid", 40);

    // reset in the 5th CALC cycle, with start also high
    start = 1'b1; op = 3'd0; a = 32'd7; b = 32'hFFFF_FFFA;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; flush = 1'b0;
    #1;
    check("midreset valid", valid_o, 0);
    check("midreset stall", stall_o, 0);
    check("midreset result", result_o, 0);
    expect_quiet("midreset no valid", 40);

    // start held through the whole busy period executes once
    start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
    @(negedge clk);
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    held = result_o;
    start = 1'b0;
    check("hold latency", lat, 33);
    check("hold result", held, 32'd14);
    expect_quiet("hold single op", 40);

    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 255); rb = $urandom_range(1, 15); end
        3: rb = -($urandom_range(1, 9));
        default: ;
      endcase
      run_op(ro, ra, rb, ref_model(ro, ra, rb), $sformatf("rand%0d op%0d", i, ro));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/exe_muldiv_seq.md
EXE_MULDIV_SEQ -- requirements
Module: exe_muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits; only 32 is required to be supported.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start_i  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op_i  input  3  RISC-V M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port op1_i  input  WIDTH  rs1 operand, already forwarded.
REQ-007 SHALL have port op2_i  input  WIDTH  rs2 operand, already forwarded.
REQ-008 SHALL have port flush_i  input  1  abort any in-flight operation.
REQ-009 SHALL have port stall_o  output  1  freeze IF/ID/EXE pipe registers.
REQ-010 SHALL have port valid_o  output  1  result_o holds a valid result this cycle.
REQ-011 SHALL have port result_o  output  WIDTH  operation result.

Function
REQ-012 SHALL implement states IDLE, CALC, DONE.
REQ-013 IDLE -> CALC when start_i=1 and no special case applies; operands, op_i and operand signs latched on that edge; iteration counter loaded with WIDTH.
REQ-014 CALC: one shift-add (multiply) or restoring subtract-shift (divide) step per cycle on magnitudes; counter decrements; CALC -> DONE when counter reaches 0 (exactly WIDTH cycles in CALC).
REQ-015 DONE: valid_o=1 for exactly one cycle; sign correction applied; DONE -> IDLE unconditionally.
REQ-016 Normal latency: valid_o high in the cycle WIDTH+1 cycles after the cycle in which start_i was accepted.
REQ-017 stall_o = (IDLE and start_i) or CALC; stall_o=0 in DONE so the pipeline advances the cycle the result is valid.
REQ-018 start_i while in CALC or DONE SHALL be ignored; no queuing.
REQ-019 MUL returns low WIDTH bits of the 2*WIDTH product; MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned, each returning the high WIDTH bits.
REQ-020 DIV/REM signed: quotient truncates toward zero; remainder takes the dividend's sign.
REQ-021 Divide by zero (op2_i=0, any divide op): IDLE -> DONE directly; quotient all-ones, remainder = op1_i; valid_o in the cycle after acceptance.
REQ-022 Signed overflow (DIV/REM, op1_i=0x80000000, op2_i=0xFFFFFFFF): IDLE -> DONE directly; quotient 0x80000000, remainder 0.
REQ-023 flush_i=1 in any state SHALL force IDLE on the next edge; valid_o=0 that next cycle; flush_i beats start_i when both are 1 in IDLE.
REQ-024 result_o SHALL hold its last value outside DONE; consumers qualify with valid_o.
REQ-025 All arithmetic SHALL be internal at 2*WIDTH bits for product and WIDTH+1 bits for partial remainder; no truncation before final selection.

Reset
REQ-026 rst_i=1 at a clock edge SHALL force state IDLE, counter 0, stall_o=0, valid_o=0, result_o=0, all internal operand registers 0.
REQ-027 Reset SHALL override flush_i and start_i, and SHALL abort an operation mid-CALC with no valid_o afterward.

Verification
REQ-028 MUL op1=7, op2=0xFFFFFFFA (-6) -> valid_o exactly 33 cycles after acceptance, result 0xFFFFFFD6; MULH same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
REQ-029 DIV op1=0xFFFFFFF9 (-7), op2=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2; stall_o high on all 33 cycles through CALC, low in DONE.
REQ-030 DIVU op2=0, op1=0x1234 -> valid_o next cycle with 0xFFFFFFFF; REMU -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 next cycle; REM -> 0.
REQ-031 Start MUL, flush_i on cycle 10 of CALC -> IDLE next cycle, no valid_o pulse; immediate new start_i accepted and produces its correct result.
REQ-032 rst_i on cycle 5 of CALC -> all outputs 0 next cycle, no later valid_o; start_i held high through busy period -> exactly one operation executed.
